// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_sequencer
// Purpose  : Multi-cycle sequencer for the shared instruction/data Memory of
//            the memory-memory core. Takes one command at a time (FETCH,
//            READ, WRITE, BRWRITE) and drives registered addresses, data and
//            strobes into Memory. It then captures the Memory outputs and
//            owns the PC.
// Ports    : clk, reset (async, active high)
//            req_valid/req_ready/req_cmd/req_addr1..3/req_data : command in
//            pc_load/pc_load_val                               : PC override
//            mem_* outputs                                     : to Memory
//            mem_iro/irt/out1..3                               : from Memory
//            ir0/ir1/opa/opb/opc/pc                            : captured state
//            rsp_valid/rsp_err                                 : completion
// Revision : 1.0  initial release
// ============================================================================
module mem_sequencer #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_cmd,
  input  logic [DATA_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_addr2,
  input  logic [DATA_WIDTH-1:0] req_addr3,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  pc_load,
  input  logic [DATA_WIDTH-1:0] pc_load_val,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] mem_sr1,
  output logic [DATA_WIDTH-1:0] mem_sr2,
  output logic [DATA_WIDTH-1:0] mem_sr3,
  output logic [DATA_WIDTH-1:0] mem_rd,
  output logic [DATA_WIDTH-1:0] mem_pc,
  output logic [DATA_WIDTH-1:0] mem_two,
  output logic                  mem_memwrite,
  output logic                  mem_writezero,
  input  logic [DATA_WIDTH-1:0] mem_iro,
  input  logic [DATA_WIDTH-1:0] mem_irt,
  input  logic [DATA_WIDTH-1:0] mem_out1,
  input  logic [DATA_WIDTH-1:0] mem_out2,
  input  logic [DATA_WIDTH-1:0] mem_out3,
  output logic [DATA_WIDTH-1:0] ir0,
  output logic [DATA_WIDTH-1:0] ir1,
  output logic [DATA_WIDTH-1:0] opa,
  output logic [DATA_WIDTH-1:0] opb,
  output logic [DATA_WIDTH-1:0] opc,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  rsp_valid,
  output logic                  rsp_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] CMD_FETCH   = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_BRWRITE = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [1:0]            cmd_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] data_q, sr1_q, sr2_q, sr3_q, rd_q, mpc_q, two_q;
  logic [DATA_WIDTH-1:0] ir0_q, ir1_q, opa_q, opb_q, opc_q;

  logic                  accept;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] fetch_pc;

  assign accept   = req_valid && (state_q == S_IDLE);
  // A PC load arriving with the fetch redirects that very fetch.
  assign fetch_pc = pc_load ? pc_load_val : pc_q;

  always_comb begin
    misaligned = 1'b0;
    case (req_cmd)
      CMD_FETCH:   misaligned = fetch_pc[0];
      CMD_READ:    misaligned = req_addr1[0] | req_addr2[0] | req_addr3[0];
      CMD_WRITE:   misaligned = req_addr1[0];
      CMD_BRWRITE: misaligned = req_addr1[0] | req_addr2[0];
      default:     misaligned = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = misaligned ? S_DONE : S_ISSUE;
      S_ISSUE:   state_d = cmd_q[1] ? S_DONE : S_CAPTURE;
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic; strobes decode from the async-reset state so that reset
  // removes a write strobe without waiting for a clock edge.
  always_comb begin
    req_ready     = (state_q == S_IDLE);
    mem_memwrite  = (state_q == S_ISSUE) && cmd_q[1];
    mem_writezero = (state_q == S_ISSUE) && (cmd_q == CMD_BRWRITE);
    rsp_valid     = (state_q == S_DONE);
    rsp_err       = (state_q == S_DONE) && err_q;
  end

  // Datapath: command latch, Memory drive registers, capture registers, PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q  <= CMD_FETCH;
      err_q  <= 1'b0;
      pc_q   <= PC_RESET;
      data_q <= '0; sr1_q <= '0; sr2_q <= '0; sr3_q <= '0;
      rd_q   <= '0; mpc_q <= '0; two_q <= '0;
      ir0_q  <= '0; ir1_q <= '0;
      opa_q  <= '0; opb_q <= '0; opc_q <= '0;
    end else begin
      if (accept) begin
        cmd_q <= req_cmd;
        err_q <= misaligned;
        // Misaligned commands leave every Memory input untouched.
        if (!misaligned) begin
          case (req_cmd)
            CMD_FETCH: begin
              mpc_q <= fetch_pc;
              two_q <= fetch_pc + DATA_WIDTH'(2);
            end
            CMD_READ: begin
              sr1_q <= req_addr1;
              sr2_q <= req_addr2;
              sr3_q <= req_addr3;
            end
            CMD_WRITE: begin
              rd_q   <= req_addr1;
              data_q <= req_data;
            end
            default: begin
              rd_q   <= req_addr1;
              data_q <= req_data;
              two_q  <= req_addr2;
            end
          endcase
        end
      end

      if (state_q == S_CAPTURE) begin
        if (cmd_q == CMD_FETCH) begin
          ir0_q <= mem_iro;
          ir1_q <= mem_irt;
        end else begin
          opa_q <= mem_out1;
          opb_q <= mem_out2;
          opc_q <= mem_out3;
        end
      end

      // External load takes priority over the fetch increment.
      if (pc_load)
        pc_q <= pc_load_val;
      else if ((state_q == S_CAPTURE) && (cmd_q == CMD_FETCH))
        pc_q <= pc_q + DATA_WIDTH'(PC_STEP);
    end
  end

  assign mem_data = data_q;
  assign mem_sr1  = sr1_q;
  assign mem_sr2  = sr2_q;
  assign mem_sr3  = sr3_q;
  assign mem_rd   = rd_q;
  assign mem_pc   = mpc_q;
  assign mem_two  = two_q;
  assign ir0      = ir0_q;
  assign ir1      = ir1_q;
  assign opa      = opa_q;
  assign opb      = opb_q;
  assign opc      = opc_q;
  assign pc       = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_sequencer
// Purpose  : Self-checking bench for mem_sequencer with a behavioural Memory
//            and a response scoreboard (directed commands, hand-computed
//            expectations).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_sequencer;

  typedef struct {
    logic        err;
    logic [15:0] ir0, ir1, opa, opb, opc, pc;
    int          wr, wz;
    int          done_cyc;
    logic        chk_m;
    logic [15:0] mpc, mtwo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cmd = 2'b00;
  logic [15:0] req_addr1 = '0, req_addr2 = '0, req_addr3 = '0, req_data = '0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = '0;
  logic [15:0] mem_data, mem_sr1, mem_sr2, mem_sr3, mem_rd, mem_pc, mem_two;
  logic        mem_memwrite, mem_writezero;
  logic [15:0] mem_iro, mem_irt, mem_out1, mem_out2, mem_out3;
  logic [15:0] ir0, ir1, opa, opb, opc, pc;
  logic        rsp_valid, rsp_err;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_cnt = 0;
  int   wz_cnt = 0;
  exp_t sb[$];

  logic [15:0] M [256];

  mem_sequencer #(.DATA_WIDTH(16), .PC_RESET(16'h0000), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr1(req_addr1), .req_addr2(req_addr2), .req_addr3(req_addr3),
    .req_data(req_data), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .mem_data(mem_data), .mem_sr1(mem_sr1), .mem_sr2(mem_sr2),
    .mem_sr3(mem_sr3), .mem_rd(mem_rd), .mem_pc(mem_pc), .mem_two(mem_two),
    .mem_memwrite(mem_memwrite), .mem_writezero(mem_writezero),
    .mem_iro(mem_iro), .mem_irt(mem_irt), .mem_out1(mem_out1),
    .mem_out2(mem_out2), .mem_out3(mem_out3),
    .ir0(ir0), .ir1(ir1), .opa(opa), .opb(opb), .opc(opc), .pc(pc),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural Memory: 2-byte words, byte address bits [8:1] select the word.
  assign mem_iro  = M[mem_pc[8:1]];
  assign mem_irt  = M[mem_two[8:1]];
  assign mem_out1 = M[mem_sr1[8:1]];
  assign mem_out2 = M[mem_sr2[8:1]];
  assign mem_out3 = M[mem_sr3[8:1]];

  always @(posedge clk) begin
    if (mem_memwrite) begin
      M[mem_rd[8:1]] <= mem_data;
      if (mem_writezero) M[mem_two[8:1]] <= 16'h0000;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t mk(input logic err, input logic [15:0] i0, i1, oa, ob, oc, p,
                              input int wr, wz, input logic cm, input logic [15:0] mpc, mtwo);
    exp_t e;
    e.err = err; e.ir0 = i0; e.ir1 = i1; e.opa = oa; e.opb = ob; e.opc = oc; e.pc = p;
    e.wr = wr; e.wz = wz; e.done_cyc = 0; e.chk_m = cm; e.mpc = mpc; e.mtwo = mtwo;
    return e;
  endfunction

  // Monitor: counts write strobes and scores every completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        wr_cnt = 0;
        wz_cnt = 0;
      end else begin
        if (mem_memwrite) wr_cnt++;
        if (mem_writezero) begin
          wz_cnt++;
          if (!mem_memwrite) fail("writezero_without_memwrite");
        end
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            fail("unexpected_rsp_valid");
          end else begin
            e = sb.pop_front();
            check("rsp_cycle", cyc, e.done_cyc);
            check("rsp_err", rsp_err, e.err);
            check("ir0", ir0, e.ir0);
            check("ir1", ir1, e.ir1);
            check("opa", opa, e.opa);
            check("opb", opb, e.opb);
            check("opc", opc, e.opc);
            check("pc", pc, e.pc);
            check("memwrite_cycles", wr_cnt, e.wr);
            check("writezero_cycles", wz_cnt, e.wz);
            if (e.chk_m) begin
              check("mem_pc", mem_pc, e.mpc);
              check("mem_two", mem_two, e.mtwo);
            end
          end
          wr_cnt = 0;
          wz_cnt = 0;
        end
      end
    end
  end

  // ldmode: 0 none, 1 pc_load together with the accept, 2 pc_load in CAPTURE.
  task automatic send(input logic [1:0] cmd, input logic [15:0] a1, a2, a3, d,
                      input exp_t e, input int lat, input bit hold,
                      input int ldmode, input logic [15:0] ldval);
    int a;
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd;
    req_addr1 = a1; req_addr2 = a2; req_addr3 = a3; req_data = d;
    if (ldmode == 1) begin pc_load = 1'b1; pc_load_val = ldval; end
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin
      fail("accept_timeout");
      req_valid = 1'b0; pc_load = 1'b0;
      return;
    end
    a = cyc;
    e.done_cyc = a + lat;
    sb.push_back(e);
    @(negedge clk);
    pc_load = 1'b0;
    if (!hold) req_valid = 1'b0;
    while (cyc < a + lat) begin
      if (ldmode == 2 && cyc == a + 2) begin pc_load = 1'b1; pc_load_val = ldval; end
      else pc_load = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    pc_load = 1'b0;
  endtask

  task automatic load_pc(input logic [15:0] v);
    @(negedge clk);
    pc_load = 1'b1; pc_load_val = v;
    @(negedge clk);
    pc_load = 1'b0;
    check("pc_after_load", pc, v);
  endtask

  initial begin
    int t;
    for (int i = 0; i < 256; i++) M[i] = 16'h0000;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_pc", pc, 16'h0000);
    check("reset_memwrite", mem_memwrite, 0);
    check("reset_mem_pc", mem_pc, 16'h0000);
    check("reset_ir0", ir0, 16'h0000);
    check("reset_opa", opa, 16'h0000);

    // Write then fetch
    send(2'b10, 16'h0000, 0, 0, 16'd5,  mk(0, 0, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, 0), 2, 0, 0, 0);
    send(2'b10, 16'h0002, 0, 0, 16'd10, mk(0, 0, 0, 0, 0, 0, 16'h0, 1, 0, 0, 0, 0), 2, 0, 0, 0);
    send(2'b00, 0, 0, 0, 0, mk(0, 16'd5, 16'd10, 0, 0, 0, 16'h4, 0, 0, 1, 16'h0, 16'h2), 3, 0, 0, 0);
    // Operand reads
    send(2'b10, 16'h0004, 0, 0, 16'd13,   mk(0, 5, 10, 0, 0, 0, 16'h4, 1, 0, 0, 0, 0), 2, 0, 0, 0);
    send(2'b10, 16'h0006, 0, 0, 16'd27,   mk(0, 5, 10, 0, 0, 0, 16'h4, 1, 0, 0, 0, 0), 2, 0, 0, 0);
    send(2'b10, 16'h0008, 0, 0, 16'h0BAD, mk(0, 5, 10, 0, 0, 0, 16'h4, 1, 0, 0, 0, 0), 2, 0, 0, 0);
    send(2'b10, 16'h0010, 0, 0, 16'h0077, mk(0, 5, 10, 0, 0, 0, 16'h4, 1, 0, 0, 0, 0), 2, 0, 0, 0);
    send(2'b01, 16'h2, 16'h4, 16'h6, 0, mk(0, 5, 10, 16'd10, 16'd13, 16'd27, 16'h4, 0, 0, 0, 0, 0), 3, 0, 0, 0);
    // Branch write, then read back
    send(2'b11, 16'h0, 16'h2, 0, 16'd56, mk(0, 5, 10, 10, 13, 27, 16'h4, 1, 1, 0, 0, 0), 2, 0, 0, 0);
    send(2'b01, 16'h0, 16'h2, 16'h4, 0, mk(0, 5, 10, 16'd56, 16'd0, 16'd13, 16'h4, 0, 0, 0, 0, 0), 3, 0, 0, 0);
    // PC wrap
    load_pc(16'hFFFC);
    send(2'b00, 0, 0, 0, 0, mk(0, 0, 0, 56, 0, 13, 16'h0000, 0, 0, 1, 16'hFFFC, 16'hFFFE), 3, 0, 0, 0);
    // pc_load coinciding with the fetch accept
    send(2'b00, 0, 0, 0, 0, mk(0, 16'h0077, 0, 56, 0, 13, 16'h0014, 0, 0, 1, 16'h0010, 16'h0012), 3, 0, 1, 16'h0010);
    // pc_load during CAPTURE wins over the increment
    send(2'b00, 0, 0, 0, 0, mk(0, 0, 0, 56, 0, 13, 16'h0040, 0, 0, 1, 16'h0014, 16'h0016), 3, 0, 2, 16'h0040);
    // Misaligned read, request held high while busy
    send(2'b01, 16'h0, 16'h3, 16'h4, 0, mk(1, 0, 0, 56, 0, 13, 16'h0040, 0, 0, 0, 0, 0), 1, 1, 0, 0);
    // Misaligned fetch: no Memory access, PC unchanged
    load_pc(16'h0041);
    send(2'b00, 0, 0, 0, 0, mk(1, 0, 0, 56, 0, 13, 16'h0041, 0, 0, 1, 16'h0014, 16'h0016), 1, 0, 0, 0);

    // Reset during ISSUE of WRITE 8 <- 0x1234
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 2'b10; req_addr1 = 16'h0008; req_data = 16'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    #2;
    check("issue_memwrite_before_reset", mem_memwrite, 1);
    reset = 1'b1;
    #1;
    check("async_memwrite_drop", mem_memwrite, 0);
    check("async_req_ready", req_ready, 1);
    check("async_pc", pc, 16'h0000);
    check("async_mem_data", mem_data, 16'h0000);
    check("async_opa", opa, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    send(2'b01, 16'h8, 16'h4, 16'h6, 0, mk(0, 0, 0, 16'h0BAD, 16'd13, 16'd27, 16'h0000, 0, 0, 0, 0, 0), 3, 0, 0, 0);

    t = 0;
    while (sb.size() != 0 && t < 20) begin @(negedge clk); t++; end
    if (sb.size() != 0) fail("missing_responses");
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Multi-cycle controller that sequences the shared data/instruction Memory block of the memory-memory core.
- Accepts one command at a time from the control unit over a valid/ready handshake: instruction fetch, three-operand read, result write, or branch write (WRITEZERO).
- Drives registered address, data and control signals into Memory, then captures the Memory outputs.
- Owns the PC, including auto-increment on fetch and external load for branches.

Parameters:
- DATA_WIDTH, 16, width of data, addresses and PC.
- PC_RESET, 0, PC value after reset.
- PC_STEP, 4, PC increment per fetch (two 2-byte words).

Ports:
- clk  in  1  clock; all registers on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  sequencer can accept a command; high only in IDLE.
- req_cmd  in  2  command: 00 FETCH, 01 READ, 10 WRITE, 11 BRWRITE.
- req_addr1  in  DATA_WIDTH  READ: sr1; WRITE/BRWRITE: rd.
- req_addr2  in  DATA_WIDTH  READ: sr2; BRWRITE: address zeroed through two.
- req_addr3  in  DATA_WIDTH  READ: sr3.
- req_data  in  DATA_WIDTH  write data.
- pc_load  in  1  load PC from pc_load_val.
- pc_load_val  in  DATA_WIDTH  branch target.
- mem_data, mem_sr1, mem_sr2, mem_sr3, mem_rd, mem_pc, mem_two  out  DATA_WIDTH each  to the matching Memory inputs.
- mem_memwrite  out  1  to Memory MEMWRITE.
- mem_writezero  out  1  to Memory WRITEZERO.
- mem_iro, mem_irt, mem_out1, mem_out2, mem_out3  in  DATA_WIDTH each  from Memory.
- ir0, ir1  out  DATA_WIDTH  captured instruction words.
- opa, opb, opc  out  DATA_WIDTH  captured operands.
- pc  out  DATA_WIDTH  current PC.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualifies rsp_valid; misaligned address, no access performed.

Behaviour:
- Reset (async):
  - State goes to IDLE; pc = PC_RESET.
  - All mem_* outputs, ir0/ir1, opa/opb/opc, rsp_valid and rsp_err go to 0.
  - An in-flight write is aborted immediately; mem_memwrite drops without waiting for a clock.
- States:
  - IDLE: req_ready = 1.
  - Accept when req_valid & req_ready, then go to ISSUE.
  - Alignment check on accept: if any address used by the command has bit0 = 1 (FETCH checks pc), go to DONE with rsp_err = 1 and perform no Memory access.
  - ISSUE, one cycle: mem_* address/data outputs hold values registered at accept.
    - WRITE: mem_memwrite = 1.
    - BRWRITE: mem_memwrite = 1 and mem_writezero = 1.
    - Writes go to DONE; FETCH and READ go to CAPTURE.
  - CAPTURE, one cycle: addresses are still held.
    - At the end of the cycle, FETCH samples ir0 <= mem_iro and ir1 <= mem_irt; READ samples opa/opb/opc <= mem_out1/2/3.
    - FETCH also does pc <= pc + PC_STEP in this cycle.
    - Then go to DONE.
  - DONE, one cycle: rsp_valid = 1 and captured registers are visible; then go to IDLE.
- Latency, counting the accept edge as cycle 0:
  - Writes: rsp_valid in cycle 2.
  - FETCH/READ: rsp_valid in cycle 3.
  - Error: rsp_valid in cycle 1.
  - Back-to-back throughput: one command per 3 cycles (writes) or 4 cycles (reads).
- Address mapping:
  - FETCH: mem_pc = pc and mem_two = pc + 2, both mod 2^DATA_WIDTH.
  - BRWRITE: mem_rd = req_addr1, mem_data = req_data, mem_two = req_addr2.
  - Unused mem_* outputs keep their previous values.
  - mem_memwrite and mem_writezero are 0 outside ISSUE.
- PC:
  - PC arithmetic wraps: 0xFFFC + 4 = 0x0000, and mem_two = 0xFFFE before the wrap.
  - pc_load is honoured in any state; the new value is visible on the next cycle.
  - If pc_load coincides with the fetch increment in CAPTURE, the load wins.
  - If pc_load coincides with a FETCH accept, that fetch uses pc_load_val, and pc = pc_load_val + PC_STEP after CAPTURE.
- req_valid while not ready: ignored, no queueing. The requester must hold the command until it sees ready.
- Captured registers hold their values until the next capture of the same kind.

Test Plan:
- Write then fetch: WRITE rd=0 data=5, WRITE rd=2 data=10, FETCH with pc=0 -> ir0=5, ir1=10, pc=4, rsp_valid in cycle 3 of the fetch, mem_memwrite high exactly one cycle per write.
- Read operands: WRITE 4<-13, WRITE 6<-27, READ sr1=2, sr2=4, sr3=6 -> opa=10, opb=13, opc=27, rsp_err=0.
- Branch write: BRWRITE rd=0, data=56, addr2=2; then READ 0,2,4 -> opa=56, opb=0, opc=13; mem_writezero asserted only in ISSUE.
- PC control:
  - pc_load=0xFFFC then FETCH -> mem_pc=0xFFFC, mem_two=0xFFFE, pc=0x0000 afterwards.
  - pc_load asserted during CAPTURE with value 0x0040 -> pc=0x0040 after the fetch, not the incremented value.
- Misaligned access: READ sr2=3 -> rsp_valid and rsp_err in cycle 1, no mem_memwrite pulse, opa/opb/opc unchanged. Holding req_valid during a busy state does not cause a second accept.
- Reset mid-write: assert reset during ISSUE of a WRITE of 0x1234 to address 8 -> mem_memwrite falls immediately, state returns to IDLE, pc=0; a following READ of address 8 returns the old contents.
